// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU / register-file control bundle between the
// fetch buffer (master) and the issue controller (slave).
interface alu_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [5:0]       alu_funct;
  logic [4:0]       alu_shamt;
  logic             alu_a_sel;
  logic [1:0]       alu_b_sel;
  logic [31:0]      imm_sext;
  logic [4:0]       rf_waddr;
  logic             rf_we;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output instr_valid, instr,
    input  instr_ready, alu_funct, alu_shamt, alu_a_sel, alu_b_sel, imm_sext,
           rf_waddr, rf_we, done, illegal, retire_cnt
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, alu_funct, alu_shamt, alu_a_sel, alu_b_sel, imm_sext,
           rf_waddr, rf_we, done, illegal, retire_cnt
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multicycle MIPS issue controller: accepts one instruction, decodes it to ALU
// op/select codes, holds them for EXEC_CYCLES plus a write-back cycle, then retires.
module alu_issue_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [5:0] FN_IDLE = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b001001;
  localparam logic [5:0] FN_SUBU = 6'b001010;
  localparam logic [5:0] FN_SLL  = 6'b100001;
  localparam logic [5:0] FN_SLLV = 6'b110101;
  localparam logic [5:0] FN_SLTI = 6'b101010;
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_exec_cnt;
  logic [3:0]       w_exec_cnt_next;
  logic [31:0]      r_instr;
  logic             w_accept;
  logic             w_unused;

  logic             w_legal;
  logic [5:0]       w_funct;
  logic [4:0]       w_shamt;
  logic             w_a_sel;
  logic [1:0]       w_b_sel;
  logic [4:0]       w_waddr;
  logic [31:0]      w_imm;

  logic             r_instr_ready;
  logic [5:0]       r_alu_funct;
  logic [4:0]       r_alu_shamt;
  logic             r_alu_a_sel;
  logic [1:0]       r_alu_b_sel;
  logic [31:0]      r_imm_sext;
  logic [4:0]       r_rf_waddr;
  logic             r_rf_we;
  logic             r_done;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_active_next;

  // rs itself is routed by the datapath; only its selects are produced here
  assign w_unused = ^r_instr[25:21];
  assign w_accept = r_instr_ready & bus.instr_valid;
  assign w_imm    = {{16{r_instr[15]}}, r_instr[15:0]};

  always_comb begin
    w_legal = 1'b0;
    w_funct = FN_IDLE;
    w_shamt = 5'd0;
    w_a_sel = 1'b0;
    w_b_sel = 2'd0;
    w_waddr = 5'd0;
    case (r_instr[31:26])
      6'b000000: begin
        case (r_instr[5:0])
          6'b100001: begin
            w_legal = 1'b1;
            w_funct = FN_ADDU;
            w_waddr = r_instr[15:11];
          end
          6'b100011: begin
            w_legal = 1'b1;
            w_funct = FN_SUBU;
            w_waddr = r_instr[15:11];
          end
          6'b000000: begin
            w_legal = 1'b1;
            w_funct = FN_SLL;
            w_a_sel = 1'b1;
            w_shamt = r_instr[10:6];
            w_waddr = r_instr[15:11];
          end
          6'b000100: begin
            w_legal = 1'b1;
            w_funct = FN_SLLV;
            w_a_sel = 1'b1;
            w_b_sel = 2'd1;
            w_waddr = r_instr[15:11];
          end
          default: ;
        endcase
      end
      6'b001001: begin
        w_legal = 1'b1;
        w_funct = FN_ADDU;
        w_b_sel = 2'd2;
        w_waddr = r_instr[20:16];
      end
      6'b001010: begin
        w_legal = 1'b1;
        w_funct = FN_SLTI;
        w_b_sel = 2'd2;
        w_waddr = r_instr[20:16];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_exec_cnt_next = r_exec_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) begin
          w_state_next    = S_EXEC;
          w_exec_cnt_next = EXEC_LAST;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_exec_cnt == 4'd0) w_state_next = S_WB;
        else                    w_exec_cnt_next = r_exec_cnt - 4'd1;
      end
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  assign w_active_next = (w_state_next == S_EXEC) || (w_state_next == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_exec_cnt    <= 4'd0;
      r_instr       <= 32'd0;
      r_instr_ready <= 1'b1;
      r_alu_funct   <= FN_IDLE;
      r_alu_shamt   <= 5'd0;
      r_alu_a_sel   <= 1'b0;
      r_alu_b_sel   <= 2'd0;
      r_imm_sext    <= 32'd0;
      r_rf_waddr    <= 5'd0;
      r_rf_we       <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_retire_cnt  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_exec_cnt    <= w_exec_cnt_next;
      if (w_accept) r_instr <= bus.instr;
      r_instr_ready <= (w_state_next == S_IDLE);
      r_alu_funct   <= w_active_next ? w_funct : FN_IDLE;
      r_alu_shamt   <= w_active_next ? w_shamt : 5'd0;
      r_alu_a_sel   <= w_active_next ? w_a_sel : 1'b0;
      r_alu_b_sel   <= w_active_next ? w_b_sel : 2'd0;
      r_imm_sext    <= w_active_next ? w_imm   : 32'd0;
      r_rf_waddr    <= w_active_next ? w_waddr : 5'd0;
      r_rf_we       <= (w_state_next == S_WB) && (w_waddr != 5'd0);
      r_done        <= (w_state_next == S_WB);
      r_illegal     <= (r_state == S_DECODE) && !w_legal;
      if (w_state_next == S_WB) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.alu_funct   = r_alu_funct;
  assign bus.alu_shamt   = r_alu_shamt;
  assign bus.alu_a_sel   = r_alu_a_sel;
  assign bus.alu_b_sel   = r_alu_b_sel;
  assign bus.imm_sext    = r_imm_sext;
  assign bus.rf_waddr    = r_rf_waddr;
  assign bus.rf_we       = r_rf_we;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;
  assign bus.retire_cnt  = r_retire_cnt;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: decode vector table, randomized traffic against a
// reference decoder, EXEC_CYCLES=3 back-to-back issue with counter wrap, async reset.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  int   exp3 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if #(.CNT_W(16)) bus1 ();
  alu_issue_ctrl_if #(.CNT_W(3))  bus3 ();

  alu_issue_ctrl #(.EXEC_CYCLES(1), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus1));
  alu_issue_ctrl #(.EXEC_CYCLES(3), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct packed {
    logic        legal;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        a;
    logic [1:0]  b;
    logic [31:0] imm;
    logic [4:0]  waddr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decoder: the mnemonic table, mapped onto the ALU's op codes
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    e = '0;
    e.imm = {{16{w[15]}}, w[15:0]};
    if (op == 6'd0) begin
      e.waddr = w[15:11];
      if (fn == 6'b100001)      begin e.legal = 1; e.funct = 6'b001001; end
      else if (fn == 6'b100011) begin e.legal = 1; e.funct = 6'b001010; end
      else if (fn == 6'b000000) begin e.legal = 1; e.funct = 6'b100001; e.a = 1; e.shamt = w[10:6]; end
      else if (fn == 6'b000100) begin e.legal = 1; e.funct = 6'b110101; e.a = 1; e.b = 2'd1; end
    end else if (op == 6'b001001) begin
      e.legal = 1; e.funct = 6'b001001; e.b = 2'd2; e.waddr = w[20:16];
    end else if (op == 6'b001010) begin
      e.legal = 1; e.funct = 6'b101010; e.b = 2'd2; e.waddr = w[20:16];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 7))
      0: begin w[31:26] = 6'd0; w[5:0] = 6'b100001; end
      1: begin w[31:26] = 6'd0; w[5:0] = 6'b100011; end
      2: begin w[31:26] = 6'd0; w[5:0] = 6'b000000; end
      3: begin w[31:26] = 6'd0; w[5:0] = 6'b000100; end
      4: w[31:26] = 6'b001001;
      5: w[31:26] = 6'b001010;
      6: w = 32'd0;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk_alu(input string tag, input exp_t e);
    chk({tag, ".funct"}, 32'(bus1.alu_funct), 32'(e.funct));
    chk({tag, ".shamt"}, 32'(bus1.alu_shamt), 32'(e.shamt));
    chk({tag, ".a_sel"}, 32'(bus1.alu_a_sel), 32'(e.a));
    chk({tag, ".b_sel"}, 32'(bus1.alu_b_sel), 32'(e.b));
    chk({tag, ".imm"},   bus1.imm_sext,       e.imm);
    chk({tag, ".waddr"}, 32'(bus1.rf_waddr),  32'(e.waddr));
  endtask

  // One complete transaction on the EXEC_CYCLES=1 unit, checked every cycle
  task automatic run1(input logic [31:0] w, input exp_t e, input string tag);
    int waited;
    waited = 0;
    while (bus1.instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".ready_idle"}, 32'(bus1.instr_ready), 32'd1);
    if (bus1.instr_ready !== 1'b1) return;
    bus1.instr_valid = 1'b1;
    bus1.instr       = w;
    @(negedge clk);
    chk({tag, ".dec_ready"},   32'(bus1.instr_ready), 32'd0);
    chk({tag, ".dec_funct"},   32'(bus1.alu_funct),   32'd0);
    chk({tag, ".dec_shamt"},   32'(bus1.alu_shamt),   32'd0);
    chk({tag, ".dec_rf_we"},   32'(bus1.rf_we),       32'd0);
    chk({tag, ".dec_illegal"}, 32'(bus1.illegal),     32'd0);
    bus1.instr = $urandom();
    @(negedge clk);
    if (!e.legal) begin
      chk({tag, ".illegal"},     32'(bus1.illegal),     32'd1);
      chk({tag, ".ill_ready"},   32'(bus1.instr_ready), 32'd1);
      chk({tag, ".ill_rf_we"},   32'(bus1.rf_we),       32'd0);
      chk({tag, ".ill_done"},    32'(bus1.done),        32'd0);
      chk({tag, ".ill_funct"},   32'(bus1.alu_funct),   32'd0);
      chk({tag, ".ill_cnt"},     32'(bus1.retire_cnt),  32'(exp_cnt));
      bus1.instr_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".ill_pulse_end"}, 32'(bus1.illegal),    32'd0);
      chk({tag, ".ill_cnt2"},      32'(bus1.retire_cnt), 32'(exp_cnt));
    end else begin
      chk_alu({tag, ".ex"}, e);
      chk({tag, ".ex_rf_we"}, 32'(bus1.rf_we),       32'd0);
      chk({tag, ".ex_done"},  32'(bus1.done),        32'd0);
      chk({tag, ".ex_ready"}, 32'(bus1.instr_ready), 32'd0);
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % 65536;
      chk_alu({tag, ".wb"}, e);
      chk({tag, ".wb_rf_we"}, 32'(bus1.rf_we),       32'(e.waddr != 5'd0));
      chk({tag, ".wb_done"},  32'(bus1.done),        32'd1);
      chk({tag, ".wb_cnt"},   32'(bus1.retire_cnt),  32'(exp_cnt));
      chk({tag, ".wb_ready"}, 32'(bus1.instr_ready), 32'd0);
      @(negedge clk);
      chk({tag, ".post_ready"}, 32'(bus1.instr_ready), 32'd1);
      chk({tag, ".post_done"},  32'(bus1.done),        32'd0);
      chk({tag, ".post_rf_we"}, 32'(bus1.rf_we),       32'd0);
      chk({tag, ".post_funct"}, 32'(bus1.alu_funct),   32'd0);
      bus1.instr_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] w3;
    exp_t        e;
    int          last_xfer;
    int          waited;

    tbl[0] = '{"addu",     32'h00221821, '{1'b1, 6'b001001, 5'd0, 1'b0, 2'd0, 32'h00001821, 5'd3}};
    tbl[1] = '{"sll",      32'h000521C0, '{1'b1, 6'b100001, 5'd7, 1'b1, 2'd0, 32'h000021C0, 5'd4}};
    tbl[2] = '{"slti",     32'h2826FFFF, '{1'b1, 6'b101010, 5'd0, 1'b0, 2'd2, 32'hFFFFFFFF, 5'd6}};
    tbl[3] = '{"lw",       32'h8C220000, '{1'b0, 6'd0,      5'd0, 1'b0, 2'd0, 32'h00000000, 5'd0}};
    tbl[4] = '{"subu",     32'h00223823, '{1'b1, 6'b001010, 5'd0, 1'b0, 2'd0, 32'h00003823, 5'd7}};
    tbl[5] = '{"sllv",     32'h01494004, '{1'b1, 6'b110101, 5'd0, 1'b1, 2'd1, 32'h00004004, 5'd8}};
    tbl[6] = '{"addiu",    32'h24498000, '{1'b1, 6'b001001, 5'd0, 1'b0, 2'd2, 32'hFFFF8000, 5'd9}};
    tbl[7] = '{"nop",      32'h00000000, '{1'b1, 6'b100001, 5'd0, 1'b1, 2'd0, 32'h00000000, 5'd0}};
    tbl[8] = '{"addu_r0",  32'h00220021, '{1'b1, 6'b001001, 5'd0, 1'b0, 2'd0, 32'h00000021, 5'd0}};
    tbl[9] = '{"sub_ill",  32'h00221822, '{1'b0, 6'd0,      5'd0, 1'b0, 2'd0, 32'h00000000, 5'd0}};

    rst = 1'b1;
    bus1.instr_valid = 1'b0;
    bus1.instr       = 32'd0;
    bus3.instr_valid = 1'b0;
    bus3.instr       = 32'd0;
    #1;
    chk("rst.ready",   32'(bus1.instr_ready), 32'd1);
    chk("rst.cnt",     32'(bus1.retire_cnt),  32'd0);
    chk("rst.funct",   32'(bus1.alu_funct),   32'd0);
    chk("rst.rf_we",   32'(bus1.rf_we),       32'd0);
    chk("rst.done",    32'(bus1.done),        32'd0);
    chk("rst.illegal", 32'(bus1.illegal),     32'd0);
    chk("rst.imm",     bus1.imm_sext,         32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run1(tbl[i].instr, tbl[i].e, tbl[i].name);
      $display("vec %0d %s instr=0x%08h retire_cnt=%0d", i, tbl[i].name, tbl[i].instr, bus1.retire_cnt);
    end

    for (int i = 0; i < 40; i++) begin
      w = rand_instr();
      e = ref_decode(w);
      run1(w, e, "rnd");
      $display("rnd %0d instr=0x%08h legal=%0d retire_cnt=%0d", i, w, e.legal, bus1.retire_cnt);
    end

    // EXEC_CYCLES=3 unit with valid held high: fixed 6-cycle issue interval and counter wrap
    last_xfer = -1;
    bus3.instr_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      waited = 0;
      while (bus3.instr_ready !== 1'b1 && waited < 12) begin
        @(negedge clk);
        waited++;
      end
      chk("b2b.ready", 32'(bus3.instr_ready), 32'd1);
      case (n % 3)
        0:       w3 = 32'h00221821;
        1:       w3 = 32'h2826FFFF;
        default: w3 = 32'h00220023;
      endcase
      e = ref_decode(w3);
      bus3.instr = w3;
      if (last_xfer >= 0) chk("b2b.interval", 32'(cyc + 1 - last_xfer), 32'd6);
      last_xfer = cyc + 1;
      @(negedge clk);
      chk("b2b.dec_ready", 32'(bus3.instr_ready), 32'd0);
      chk("b2b.dec_funct", 32'(bus3.alu_funct),   32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("b2b.ex_funct", 32'(bus3.alu_funct),   32'(e.funct));
        chk("b2b.ex_b_sel", 32'(bus3.alu_b_sel),   32'(e.b));
        chk("b2b.ex_done",  32'(bus3.done),        32'd0);
        chk("b2b.ex_rf_we", 32'(bus3.rf_we),       32'd0);
        chk("b2b.ex_ready", 32'(bus3.instr_ready), 32'd0);
      end
      @(negedge clk);
      exp3 = (exp3 + 1) % 8;
      chk("b2b.wb_funct", 32'(bus3.alu_funct),  32'(e.funct));
      chk("b2b.wb_done",  32'(bus3.done),       32'd1);
      chk("b2b.wb_rf_we", 32'(bus3.rf_we),      32'(e.waddr != 5'd0));
      chk("b2b.wb_cnt",   32'(bus3.retire_cnt), 32'(exp3));
      @(negedge clk);
      chk("b2b.idle_funct", 32'(bus3.alu_funct), 32'd0);
      chk("b2b.idle_done",  32'(bus3.done),      32'd0);
      $display("b2b %0d instr=0x%08h retire_cnt=%0d", n, w3, bus3.retire_cnt);
    end
    bus3.instr_valid = 1'b0;

    // Asynchronous reset while in EXEC, then a normal instruction
    @(negedge clk);
    chk("ar.ready_idle", 32'(bus1.instr_ready), 32'd1);
    bus1.instr_valid = 1'b1;
    bus1.instr       = 32'h00221821;
    @(negedge clk);
    bus1.instr_valid = 1'b0;
    @(negedge clk);
    chk("ar.in_exec_funct", 32'(bus1.alu_funct), 32'b001001);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.ready",   32'(bus1.instr_ready), 32'd1);
    chk("ar.funct",   32'(bus1.alu_funct),   32'd0);
    chk("ar.waddr",   32'(bus1.rf_waddr),    32'd0);
    chk("ar.imm",     bus1.imm_sext,         32'd0);
    chk("ar.rf_we",   32'(bus1.rf_we),       32'd0);
    chk("ar.done",    32'(bus1.done),        32'd0);
    chk("ar.cnt",     32'(bus1.retire_cnt),  32'd0);
    @(negedge clk);
    chk("ar.held_rf_we", 32'(bus1.rf_we), 32'd0);
    chk("ar.held_done",  32'(bus1.done),  32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("ar.post_ready", 32'(bus1.instr_ready), 32'd1);
    run1(32'h00221821, ref_decode(32'h00221821), "ar_next");
    $display("areset recovery retire_cnt=%0d", bus1.retire_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
